udma_l2_responder: RTL

UDMA_L2_RESPONDER -- requirements
Module: udma_l2_responder

---
 rtl/udma_l2_responder_pkg.sv | 16 +
 rtl/udma_l2_rr_arb2.sv | 36 +++
 rtl/udma_l2_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/udma_l2_responder_pkg.sv
// Shared types and constants for the uDMA L2 responder: port-select encoding
// and the fill pattern returned for accesses that miss the SRAM window.
package udma_l2_responder_pkg;

  typedef enum logic {
    PORT_RO = 1'b0,
    PORT_WO = 1'b1
  } port_sel_e;

  localparam logic [31:0] ERR_PATTERN = 32'hBADC_AB1E;

  function automatic port_sel_e other_port(input port_sel_e p);
    return (p == PORT_RO) ? PORT_WO : PORT_RO;
  endfunction

endpackage

// File: rtl/udma_l2_rr_arb2.sv
// Two-input round-robin arbiter. The winner is combinational; the priority
// pointer only moves when both inputs requested and the caller confirms a grant.
module udma_l2_rr_arb2
  import udma_l2_responder_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req_ro,
  input  logic      req_wo,
  input  logic      update_en,
  output logic      valid,
  output port_sel_e winner
);

  port_sel_e ptr_q;

  always_comb begin
    valid  = req_ro | req_wo;
    winner = PORT_RO;
    if (req_ro && req_wo) begin
      winner = ptr_q;
    end else if (req_wo) begin
      winner = PORT_WO;
    end
  end

  // Favour the loser next time, but only once the contested access really went through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PORT_RO;
    end else if (update_en && req_ro && req_wo) begin
      ptr_q <= other_port(winner);
    end
  end

endmodule

// File: rtl/udma_l2_responder.sv
// Bridges the uDMA read-only and write-only L2 ports onto one single-port SRAM,
// answering out-of-window accesses locally with an error pattern.
module udma_l2_responder
  import udma_l2_responder_pkg::*;
#(
  parameter int unsigned L2_DATA_WIDTH  = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_ni,

  input  logic                         L2_ro_req_i,
  input  logic                         L2_ro_wen_i,
  input  logic [31:0]                  L2_ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_ro_wdata_i,
  output logic                         L2_ro_gnt_o,
  output logic                         L2_ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_ro_rdata_o,

  input  logic                         L2_wo_req_i,
  input  logic                         L2_wo_wen_i,
  input  logic [31:0]                  L2_wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_wo_wdata_i,
  output logic                         L2_wo_gnt_o,
  output logic                         L2_wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_wo_rdata_o,

  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [L2_DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic [L2_DATA_WIDTH-1:0]     mem_rdata_i,

  output logic [15:0]                  err_count_o
);

  localparam int unsigned BE_WIDTH   = L2_DATA_WIDTH / 8;
  localparam int unsigned WORD_SHIFT = $clog2(BE_WIDTH);

  function automatic logic [L2_DATA_WIDTH-1:0] err_data();
    logic [L2_DATA_WIDTH+31:0] rep;
    rep = '0;
    for (int i = 0; i < (L2_DATA_WIDTH + 31) / 32; i++) begin
      rep = (rep << 32) | {{L2_DATA_WIDTH{1'b0}}, ERR_PATTERN};
    end
    return rep[L2_DATA_WIDTH-1:0];
  endfunction

  localparam logic [L2_DATA_WIDTH-1:0] ERR_DATA = err_data();

  // Direction is fixed by the port, so these inputs carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{L2_ro_wen_i, L2_wo_wen_i, L2_ro_wdata_i};

  logic        run_q;
  logic        arb_valid;
  port_sel_e   winner;
  logic [31:0] win_addr;
  logic [31:0] word;
  logic        in_range;
  logic        granted;
  logic        mem_fire;

  logic        rsp_valid_q;
  port_sel_e   rsp_port_q;
  logic        rsp_oor_q;
  logic [15:0] err_count_q;

  // run_q keeps every request masked until the first clock after reset release.
  udma_l2_rr_arb2 u_arb (
    .clk       (sys_clk_i),
    .rst_n     (sys_rst_ni),
    .req_ro    (run_q & L2_ro_req_i),
    .req_wo    (run_q & L2_wo_req_i),
    .update_en (granted),
    .valid     (arb_valid),
    .winner    (winner)
  );

  always_comb begin
    win_addr = (winner == PORT_WO) ? L2_wo_addr_i : L2_ro_addr_i;
    word     = (win_addr - BASE_ADDR) >> WORD_SHIFT;
    in_range = (win_addr >= BASE_ADDR) && ((word >> MEM_ADDR_WIDTH) == 32'd0);
    mem_fire = arb_valid && in_range;
    granted  = arb_valid && (!in_range || mem_gnt_i);
  end

  always_comb begin
    L2_ro_gnt_o = granted && (winner == PORT_RO);
    L2_wo_gnt_o = granted && (winner == PORT_WO);
    mem_req_o   = mem_fire;
    mem_we_o    = mem_fire && (winner == PORT_WO);
    mem_addr_o  = mem_fire ? word[MEM_ADDR_WIDTH-1:0] : '0;
    mem_be_o    = '0;
    if (mem_fire) begin
      mem_be_o = (winner == PORT_WO) ? L2_wo_be_i : L2_ro_be_i;
    end
    mem_wdata_o = mem_we_o ? L2_wo_wdata_i : '0;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      run_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_RO;
      rsp_oor_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      run_q       <= 1'b1;
      rsp_valid_q <= granted;
      if (granted) begin
        rsp_port_q <= winner;
        rsp_oor_q  <= !in_range;
      end
      if (granted && !in_range && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  // SRAM read data arrives in the response cycle, so it is passed straight through.
  always_comb begin
    L2_ro_rvalid_o = rsp_valid_q && (rsp_port_q == PORT_RO);
    L2_wo_rvalid_o = rsp_valid_q && (rsp_port_q == PORT_WO);
    L2_ro_rdata_o  = '0;
    if (L2_ro_rvalid_o) begin
      L2_ro_rdata_o = rsp_oor_q ? ERR_DATA : mem_rdata_i;
    end
    L2_wo_rdata_o  = '0;
  end

  assign err_count_o = err_count_q;

endmodule
